sp_mem_ctrl: RTL and testbench
==============================

# sp_mem_ctrl

Request-driven access controller acting as the initiator for the `single_port` RAM (`cs`/`we`/`oe`/`address`/`data`/`data_out`). It accepts read/write requests through a valid/ready port and buffers them in a small FIFO. It sequences each request onto the RAM strobes and returns read data through a valid/ready response port with backpressure. It sits between bus-side logic and the RAM macro, and replaces hand-driven strobe sequences.

## Interface
Parameters:
- `WIDTH`, 8: data width.
- `ADDR_W`, 8: address width.
- `RAM_DEPTH`, 16: number of valid words; addresses ≥ `RAM_DEPTH` are out of range.
- `FIFO_DEPTH`, 4: request FIFO entries; must be a power of 2, ≥ 2.
- `RD_LAT`, 1: RAM read latency in cycles; must be ≥ 1.

Ports (one clock; reset is asynchronous and active-low):
- `clk` in 1: clock; all state updates on rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: equals `!fifo_full`.
- `req_we` in 1: 1 = write, 0 = read.
- `req_addr` in `ADDR_W`: word address.
- `req_wdata` in `WIDTH`: write data.
- `rsp_valid` out 1: read response present.
- `rsp_ready` in 1: consumer accepts response.
- `rsp_rdata` out `WIDTH`: read data.
- `rsp_err` out 1: response is for an out-of-range read.
- `mem_cs` out 1: RAM chip select.
- `mem_we` out 1: RAM write enable.
- `mem_oe` out 1: RAM output enable.
- `mem_addr` out `ADDR_W`: RAM address.
- `mem_data` out `WIDTH`: RAM write data.
- `mem_data_out` in `WIDTH`: RAM read data.
- `busy` out 1: FIFO not empty or FSM not in IDLE.

## Operation
- Request FIFO: a push happens when `req_valid && req_ready`. Each entry holds {we, addr, wdata}.
  - A push and a pop may occur in the same cycle.
  - When the FIFO is full, `req_ready`=0 even if a pop occurs that cycle.
- FSM states: IDLE, ACCESS, WAIT, RESP.
  - **IDLE:** if the FIFO is non-empty, pop the head into the `mem_*` output registers and go to ACCESS. Otherwise stay in IDLE.
  - **ACCESS (1 cycle), in-range write:** `mem_cs`=1, `mem_we`=1, `mem_oe`=0. Then go to IDLE.
  - **ACCESS, in-range read:** `mem_cs`=1, `mem_we`=0, `mem_oe`=1. Load the wait counter with `RD_LAT`-1 and go to WAIT.
  - **ACCESS, out-of-range write:** all strobes stay 0. The write is dropped and the FSM goes to IDLE.
  - **ACCESS, out-of-range read:** all strobes stay 0. Load `rsp_rdata`=0 and `rsp_err`=1, then go to RESP.
  - **WAIT:** hold `mem_cs`=1, `mem_oe`=1 and the address. When the counter reaches 0, capture `mem_data_out` into `rsp_rdata`, set `rsp_err`=0, and go to RESP. Otherwise decrement the counter.
  - **RESP:** `rsp_valid`=1, with `rsp_rdata` and `rsp_err` held stable. Strobes are 0. On `rsp_ready`, go to IDLE.
- RAM contract:
  - A write commits at the rising edge where `cs && we`.
  - Read data is valid `RD_LAT` edges after the first edge sampling `cs && oe && !we`, and is held while `cs && oe` stay asserted.
- Requests are executed strictly in order. There is no response for writes.
- Address range check: `addr < RAM_DEPTH`, evaluated at the pop.

## Timing
- Reset values: `req_ready`=1, `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0, `mem_cs`=0, `mem_we`=0, `mem_oe`=0, `mem_addr`=0, `mem_data`=0, `busy`=0. State is IDLE and the FIFO is empty.
- All `mem_*` and `rsp_*` outputs are registered; there are no combinational paths from request inputs to them. `req_ready` derives from the FIFO count only.
- Write cadence, with the request accepted at edge E0:
  - Pop at E1; strobes high in the cycle E1–E2; the RAM commits at E2.
  - Back-to-back writes: one every 2 cycles.
- Read cadence, with the request accepted at E0:
  - Strobes high from E1 to E2+`RD_LAT`-1.
  - Data captured at E1+`RD_LAT`+1; `rsp_valid` is high after that edge. With `RD_LAT`=1, `rsp_valid` rises 3 edges after acceptance.
- Backpressure: if `rsp_ready`=0, RESP holds indefinitely and the FIFO keeps filling up to `FIFO_DEPTH`.
- Reset mid-operation: all outputs and strobes drop immediately (asynchronously). FIFO contents and any in-flight request are discarded. A write whose ACCESS cycle did not complete before reset is not guaranteed to have committed.

## Test plan
- **Write then read:** write 0x5A to addr 0x00 and 0x4B to addr 0x01, then read 0x00 and 0x01.
  - Responses: 0x5A then 0x4B, `rsp_err`=0.
  - First read `rsp_valid` at exactly acceptance+3 edges (`RD_LAT`=1).
- **FIFO full:** hold `rsp_ready`=0, issue 1 read plus 5 further requests.
  - The read sits in RESP and 4 requests fill the FIFO; `req_ready`=0 on the 6th.
  - Releasing `rsp_ready` drains the FIFO in order with no loss.
- **Out of range:** write 0xFF to addr 0x10, then read 0x10.
  - No `mem_cs` pulse for either request.
  - Read response: `rsp_rdata`=0x00, `rsp_err`=1.
  - A subsequent read of 0x00 still returns the previously written value.
- **Latency parameter:** with `RD_LAT`=3 and a RAM model to match, a read of a written value returns the correct data.
  - `mem_cs`/`mem_oe` high for 3 cycles.
  - `rsp_valid` at acceptance+5 edges.
- **Reset mid-read:** assert `rst_n`=0 during WAIT.
  - All outputs reach their reset values without waiting for a clock edge, and `busy`=0.
  - After release, a fresh read returns the correct data.
- **Back-to-back writes:** 4 writes with `req_valid` held high.
  - `mem_cs` pulses every 2nd cycle with the correct addr/data pairs.
  - `busy` falls 1 cycle after the last strobe cycle.

Source files
------------

// File: rtl/sp_mem_ctrl.sv
// sp_mem_ctrl: buffers read/write requests in a small FIFO and sequences each one
// onto single-port RAM strobes, returning read data on a valid/ready response port.
module sp_mem_ctrl #(
  parameter int WIDTH      = 8,
  parameter int ADDR_W     = 8,
  parameter int RAM_DEPTH  = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int RD_LAT     = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [WIDTH-1:0]  req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [WIDTH-1:0]  rsp_rdata,
  output logic              rsp_err,
  output logic              mem_cs,
  output logic              mem_we,
  output logic              mem_oe,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WIDTH-1:0]  mem_data,
  input  logic [WIDTH-1:0]  mem_data_out,
  output logic              busy
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int LAT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam int ENT_W = 1 + ADDR_W + WIDTH;
  localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W + 1)'(RAM_DEPTH);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WAIT, S_RESP} state_t;

  state_t                   state_q, state_d;
  logic [ENT_W-1:0]         fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]         count_q, count_d;
  logic [LAT_W-1:0]         wait_cnt_q, wait_cnt_d;
  logic                     acc_we_q, acc_we_d, acc_ok_q, acc_ok_d;
  logic                     mem_cs_q, mem_cs_d, mem_we_q, mem_we_d, mem_oe_q, mem_oe_d;
  logic [ADDR_W-1:0]        mem_addr_q, mem_addr_d;
  logic [WIDTH-1:0]         mem_data_q, mem_data_d;
  logic                     rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
  logic [WIDTH-1:0]         rsp_rdata_q, rsp_rdata_d;
  logic                     head_we, head_ok, fifo_empty, push, pop;
  logic [ADDR_W-1:0]        head_addr;
  logic [WIDTH-1:0]         head_wdata;

  assign fifo_empty = (count_q == '0);
  assign req_ready  = (count_q != FULL_CNT);
  assign push       = req_valid && req_ready;
  assign {head_we, head_addr, head_wdata} = fifo_mem[rd_ptr_q];
  assign head_ok    = ({1'b0, head_addr} < DEPTH_LIM);
  assign busy       = !fifo_empty || (state_q != S_IDLE);

  assign mem_cs    = mem_cs_q;
  assign mem_we    = mem_we_q;
  assign mem_oe    = mem_oe_q;
  assign mem_addr  = mem_addr_q;
  assign mem_data  = mem_data_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

  // FIFO storage carries no reset; only pointers and count are cleared.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= {req_we, req_addr, req_wdata};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      wait_cnt_q  <= '0;
      acc_we_q    <= 1'b0;
      acc_ok_q    <= 1'b0;
      mem_cs_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_oe_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_data_q  <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      wait_cnt_q  <= wait_cnt_d;
      acc_we_q    <= acc_we_d;
      acc_ok_q    <= acc_ok_d;
      mem_cs_q    <= mem_cs_d;
      mem_we_q    <= mem_we_d;
      mem_oe_q    <= mem_oe_d;
      mem_addr_q  <= mem_addr_d;
      mem_data_q  <= mem_data_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (!fifo_empty) state_d = S_ACCESS;
      S_ACCESS: if (acc_we_q) state_d = S_IDLE;
                else if (acc_ok_q) state_d = S_WAIT;
                else state_d = S_RESP;
      S_WAIT:   if (wait_cnt_q == '0) state_d = S_RESP;
      S_RESP:   if (rsp_ready) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    wait_cnt_d  = wait_cnt_q;
    acc_we_d    = acc_we_q;
    acc_ok_d    = acc_ok_q;
    mem_cs_d    = mem_cs_q;
    mem_we_d    = mem_we_q;
    mem_oe_d    = mem_oe_q;
    mem_addr_d  = mem_addr_q;
    mem_data_d  = mem_data_q;
    rsp_valid_d = rsp_valid_q;
    rsp_err_d   = rsp_err_q;
    rsp_rdata_d = rsp_rdata_q;
    pop         = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          acc_we_d   = head_we;
          acc_ok_d   = head_ok;
          mem_addr_d = head_addr;
          mem_data_d = head_wdata;
          mem_cs_d   = head_ok;
          mem_we_d   = head_ok && head_we;
          mem_oe_d   = head_ok && !head_we;
        end
      end
      S_ACCESS: begin
        if (acc_we_q) begin
          mem_cs_d = 1'b0;
          mem_we_d = 1'b0;
        end else if (acc_ok_q) begin
          wait_cnt_d = LAT_W'(RD_LAT - 1);
          // Strobes cover exactly RD_LAT sampling edges, then the RAM holds its output.
          if (RD_LAT == 1) begin
            mem_cs_d = 1'b0;
            mem_oe_d = 1'b0;
          end
        end else begin
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b1;
          rsp_valid_d = 1'b1;
        end
      end
      S_WAIT: begin
        if (wait_cnt_q == '0) begin
          rsp_rdata_d = mem_data_out;
          rsp_err_d   = 1'b0;
          rsp_valid_d = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q - 1'b1;
          if (wait_cnt_q == LAT_W'(1)) begin
            mem_cs_d = 1'b0;
            mem_oe_d = 1'b0;
          end
        end
      end
      S_RESP: if (rsp_ready) rsp_valid_d = 1'b0;
      default: ;
    endcase
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: ;
    endcase
  end
endmodule

// File: tb/tb_sp_mem_ctrl.sv
// Bench for sp_mem_ctrl: directed and random requests against a behavioural memory
// model, with RAM models for RD_LAT=1 and RD_LAT=3 instances.
`timescale 1ns/1ps

module tb_sp_mem_ctrl;
  int n_pass = 0;
  int n_fail = 0;
  int cyc = 0;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    if (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // DUT A: RD_LAT=1
  logic       a_req_valid, a_req_ready, a_req_we, a_rsp_valid, a_rsp_ready, a_rsp_err;
  logic       a_cs, a_we, a_oe, a_busy;
  logic [7:0] a_req_addr, a_req_wdata, a_rsp_rdata, a_addr, a_data, a_dout;
  // DUT B: RD_LAT=3
  logic       b_req_valid, b_req_ready, b_req_we, b_rsp_valid, b_rsp_ready, b_rsp_err;
  logic       b_cs, b_we, b_oe, b_busy;
  logic [7:0] b_req_addr, b_req_wdata, b_rsp_rdata, b_addr, b_data, b_dout;

  sp_mem_ctrl #(.WIDTH(8), .ADDR_W(8), .RAM_DEPTH(16), .FIFO_DEPTH(4), .RD_LAT(1)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .req_valid(a_req_valid), .req_ready(a_req_ready),
    .req_we(a_req_we), .req_addr(a_req_addr), .req_wdata(a_req_wdata),
    .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready), .rsp_rdata(a_rsp_rdata),
    .rsp_err(a_rsp_err), .mem_cs(a_cs), .mem_we(a_we), .mem_oe(a_oe),
    .mem_addr(a_addr), .mem_data(a_data), .mem_data_out(a_dout), .busy(a_busy));

  sp_mem_ctrl #(.WIDTH(8), .ADDR_W(8), .RAM_DEPTH(16), .FIFO_DEPTH(4), .RD_LAT(3)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .req_valid(b_req_valid), .req_ready(b_req_ready),
    .req_we(b_req_we), .req_addr(b_req_addr), .req_wdata(b_req_wdata),
    .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_rdata(b_rsp_rdata),
    .rsp_err(b_rsp_err), .mem_cs(b_cs), .mem_we(b_we), .mem_oe(b_oe),
    .mem_addr(b_addr), .mem_data(b_data), .mem_data_out(b_dout), .busy(b_busy));

  // RAM models: data appears RD_LAT edges after the first read-strobe edge, then holds.
  logic [7:0] a_ram [256];
  logic [7:0] b_ram [256];
  int a_rd_n = 0;
  int b_rd_n = 0;
  always @(posedge clk) begin
    if (a_cs && a_we) a_ram[a_addr] <= a_data;
    if (a_cs && a_oe && !a_we) begin
      a_rd_n <= a_rd_n + 1;
      if (a_rd_n == 0) a_dout <= a_ram[a_addr];
    end else a_rd_n <= 0;
    if (b_cs && b_we) b_ram[b_addr] <= b_data;
    if (b_cs && b_oe && !b_we) begin
      b_rd_n <= b_rd_n + 1;
      if (b_rd_n == 0) b_dout <= 'x;
      if (b_rd_n == 2) b_dout <= b_ram[b_addr];
    end else b_rd_n <= 0;
  end

  typedef struct packed { logic [7:0] a; logic [7:0] d; } wr_t;
  typedef struct packed { logic [7:0] d; logic e; } rs_t;
  wr_t wlog[$];
  wr_t exp_w[$];
  rs_t rlog[$];
  rs_t exp_r[$];
  int  wcyc[$];
  int  a_cs_n = 0;
  logic [7:0] mdl_mem [16];

  always @(posedge clk) begin
    if (a_cs) a_cs_n <= a_cs_n + 1;
    if (a_cs && a_we) begin
      wlog.push_back('{a: a_addr, d: a_data});
      wcyc.push_back(cyc);
    end
    if (a_rsp_valid && a_rsp_ready) rlog.push_back('{d: a_rsp_rdata, e: a_rsp_err});
  end

  // Present one request to DUT A, wait for acceptance, and record what the model expects.
  task automatic send(input logic we, input logic [7:0] addr, input logic [7:0] data,
                      input bit rnd_ready);
    bit ok;
    int n;
    n = 0;
    a_req_valid = 1'b1;
    a_req_we    = we;
    a_req_addr  = addr;
    a_req_wdata = data;
    do begin
      ok = a_req_ready;
      if (rnd_ready) a_rsp_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      n++;
    end while (!ok && n < 300);
    check("accept", ok, 1'b1);
    a_req_valid = 1'b0;
    if (we) begin
      if (addr < 8'd16) begin
        mdl_mem[addr[3:0]] = data;
        exp_w.push_back('{a: addr, d: data});
      end
    end else if (addr < 8'd16) exp_r.push_back('{d: mdl_mem[addr[3:0]], e: 1'b0});
    else exp_r.push_back('{d: 8'h00, e: 1'b1});
  endtask

  task automatic drain(input string tag);
    int n;
    wr_t ow, ew;
    rs_t orr, er;
    n = 0;
    a_rsp_ready = 1'b1;
    while ((a_busy || a_rsp_valid || wlog.size() < exp_w.size() || rlog.size() < exp_r.size())
           && n < 600) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "/wr_count"}, wlog.size(), exp_w.size());
    check({tag, "/rd_count"}, rlog.size(), exp_r.size());
    while (wlog.size() > 0 && exp_w.size() > 0) begin
      ow = wlog.pop_front();
      ew = exp_w.pop_front();
      $display("%s: write addr=%02h data=%02h (expect %02h/%02h)", tag, ow.a, ow.d, ew.a, ew.d);
      check({tag, "/write"}, ow, ew);
    end
    while (rlog.size() > 0 && exp_r.size() > 0) begin
      orr = rlog.pop_front();
      er  = exp_r.pop_front();
      $display("%s: read rdata=%02h err=%0b (expect %02h/%0b)", tag, orr.d, orr.e, er.d, er.e);
      check({tag, "/read"}, orr, er);
    end
    wlog.delete(); exp_w.delete(); rlog.delete(); exp_r.delete(); wcyc.delete();
  endtask

  initial begin
    int n, cs_before, cs_cnt;
    logic prev_cs;
    rst_n = 1'b0;
    a_req_valid = 1'b0; a_req_we = 1'b0; a_req_addr = '0; a_req_wdata = '0; a_rsp_ready = 1'b1;
    b_req_valid = 1'b0; b_req_we = 1'b0; b_req_addr = '0; b_req_wdata = '0; b_rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst/req_ready", a_req_ready, 1'b1);
    check("rst/rsp_valid", a_rsp_valid, 1'b0);
    check("rst/rsp_rdata", a_rsp_rdata, 8'h00);
    check("rst/rsp_err", a_rsp_err, 1'b0);
    check("rst/strobes", {a_cs, a_we, a_oe}, 3'b000);
    check("rst/mem_addr", a_addr, 8'h00);
    check("rst/mem_data", a_data, 8'h00);
    check("rst/busy", a_busy, 1'b0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst/busy", a_busy, 1'b0);

    // Prefill all words, then the directed write pair.
    for (int i = 0; i < 16; i++) send(1'b1, 8'(i), 8'($urandom), 1'b0);
    send(1'b1, 8'h00, 8'h5A, 1'b0);
    send(1'b1, 8'h01, 8'h4B, 1'b0);
    drain("prefill");

    // First read: rsp_valid must rise exactly 3 edges after acceptance.
    send(1'b0, 8'h00, 8'h00, 1'b0);
    @(posedge clk); #1;
    check("lat1/e1_valid", a_rsp_valid, 1'b0);
    @(posedge clk); #1;
    check("lat1/e2_valid", a_rsp_valid, 1'b0);
    @(posedge clk); #1;
    check("lat1/e3_valid", a_rsp_valid, 1'b1);
    check("lat1/e3_rdata", a_rsp_rdata, 8'h5A);
    send(1'b0, 8'h01, 8'h00, 1'b0);
    drain("wr_then_rd");

    // Back-to-back writes with req_valid held high.
    for (int i = 0; i < 4; i++) send(1'b1, 8'(8 + i), 8'($urandom), 1'b0);
    n = 0;
    prev_cs = a_cs;
    while (a_busy && n < 50) begin
      prev_cs = a_cs;
      @(posedge clk); #1;
      n++;
    end
    check("b2b/busy_fell", a_busy, 1'b0);
    check("b2b/strobe_before_idle", prev_cs, 1'b1);
    check("b2b/pulses", wcyc.size(), 4);
    for (int i = 0; i < 3 && i + 1 < wcyc.size(); i++) begin
      check("b2b/spacing", wcyc[i + 1] - wcyc[i], 2);
    end
    drain("b2b");

    // FIFO full under response backpressure.
    a_rsp_ready = 1'b0;
    send(1'b0, 8'h02, 8'h00, 1'b0);
    send(1'b1, 8'h02, 8'h11, 1'b0);
    send(1'b0, 8'h02, 8'h00, 1'b0);
    send(1'b1, 8'h03, 8'h22, 1'b0);
    send(1'b0, 8'h03, 8'h00, 1'b0);
    check("full/rsp_valid", a_rsp_valid, 1'b1);
    check("full/rsp_rdata", a_rsp_rdata, exp_r[0].d);
    a_req_valid = 1'b1; a_req_we = 1'b0; a_req_addr = 8'h01;
    for (int i = 0; i < 3; i++) begin
      check("full/req_ready", a_req_ready, 1'b0);
      @(posedge clk); #1;
    end
    check("full/held_valid", a_rsp_valid, 1'b1);
    a_rsp_ready = 1'b1;
    send(1'b0, 8'h01, 8'h00, 1'b0);
    drain("fifo_full");

    // Out-of-range requests never strobe the RAM.
    cs_before = a_cs_n;
    send(1'b1, 8'h10, 8'hFF, 1'b0);
    send(1'b0, 8'h10, 8'h00, 1'b0);
    drain("oor");
    check("oor/no_cs", a_cs_n, cs_before);
    send(1'b0, 8'h00, 8'h00, 1'b0);
    drain("oor_after");

    // Random mix including out-of-range addresses and random backpressure.
    for (int i = 0; i < 40; i++)
      send(1'($urandom_range(0, 1)), 8'($urandom_range(0, 19)), 8'($urandom), 1'b1);
    drain("random");

    // DUT B (RD_LAT=3): write, then read with latency and strobe-width checks.
    b_req_valid = 1'b1; b_req_we = 1'b1; b_req_addr = 8'h05; b_req_wdata = 8'hC3;
    @(posedge clk); #1;
    b_req_valid = 1'b0;
    b_req_addr = 8'h06; b_req_wdata = 8'h96;
    repeat (3) @(posedge clk);
    #1;
    b_req_valid = 1'b1;
    @(posedge clk); #1;
    b_req_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    $display("lat3: writes 05<=c3 06<=96 issued");
    b_req_valid = 1'b1; b_req_we = 1'b0; b_req_addr = 8'h05;
    @(posedge clk); #1;
    b_req_valid = 1'b0;
    cs_cnt = 0;
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk); #1;
      if (b_cs && b_oe) cs_cnt++;
      if (k < 5) begin
        check("lat3/valid_early", b_rsp_valid, 1'b0);
      end
    end
    $display("lat3: read addr=05 rdata=%02h err=%0b", b_rsp_rdata, b_rsp_err);
    check("lat3/valid_e5", b_rsp_valid, 1'b1);
    check("lat3/rdata", b_rsp_rdata, 8'hC3);
    check("lat3/err", b_rsp_err, 1'b0);
    check("lat3/strobe_cycles", cs_cnt, 3);
    @(posedge clk); #1;

    // Reset during WAIT: outputs drop with no clock edge.
    b_req_valid = 1'b1; b_req_addr = 8'h06;
    @(posedge clk); #1;
    b_req_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rstmid/in_wait_cs", b_cs, 1'b1);
    rst_n = 1'b0;
    #1;
    check("rstmid/strobes", {b_cs, b_we, b_oe}, 3'b000);
    check("rstmid/rsp_valid", b_rsp_valid, 1'b0);
    check("rstmid/rsp_rdata", b_rsp_rdata, 8'h00);
    check("rstmid/rsp_err", b_rsp_err, 1'b0);
    check("rstmid/mem_addr", b_addr, 8'h00);
    check("rstmid/mem_data", b_data, 8'h00);
    check("rstmid/busy", b_busy, 1'b0);
    check("rstmid/req_ready", b_req_ready, 1'b1);
    #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    b_req_valid = 1'b1; b_req_addr = 8'h06;
    @(posedge clk); #1;
    b_req_valid = 1'b0;
    n = 0;
    while (!b_rsp_valid && n < 12) begin
      @(posedge clk); #1;
      n++;
    end
    $display("rstmid: fresh read addr=06 rdata=%02h err=%0b", b_rsp_rdata, b_rsp_err);
    check("rstmid/fresh_valid", b_rsp_valid, 1'b1);
    check("rstmid/fresh_rdata", b_rsp_rdata, 8'h96);
    @(posedge clk); #1;

    $display("%0d/%0d checks passed", n_pass, n_pass + n_fail);
    $finish;
  end
endmodule
